// File: rtl/mips_ctl_pkg.sv
// Shared definitions for the multicycle MIPS control path.
//   - opcode constants for the supported instruction subset
//   - ALU operation codes consumed by alu_ctl
//   - datapath mux-select constants
//   - FSM state enum and the bundled control-output struct
package mips_ctl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_SLTI  = 2'b11;

    localparam logic       SRCA_PC  = 1'b0;
    localparam logic       SRCA_REG = 1'b1;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_REG    = 2'b11;

    localparam logic [1:0] REGDST_RT  = 2'b00;
    localparam logic [1:0] REGDST_RD  = 2'b01;
    localparam logic [1:0] REGDST_R31 = 2'b10;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_ADDR,
        S_MEM_READ,
        S_MEM_WB,
        S_MEM_WRITE,
        S_R_EXEC,
        S_R_WB,
        S_IMM_EXEC,
        S_IMM_WB,
        S_BRANCH,
        S_JUMP,
        S_JAL,
        S_JR,
        S_ILLEGAL
    } state_t;

    typedef struct packed {
        logic [1:0] alu_operation;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_eq;
        logic       pc_write_ne;
        logic [1:0] pc_src;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       instr_done;
        logic       illegal;
    } ctl_out_t;

endpackage

// File: rtl/ctl_state_decode.sv
// Combinational output decode for the multicycle control FSM.
// Ports:
//   state     - current FSM state
//   op_q      - opcode latched in DECODE (selects beq/bne, addi/slti)
//   mem_ready - memory handshake; gates the FETCH and MEM_WRITE strobes
//   ctl       - bundled datapath controls (all zero unless set below)
module ctl_state_decode
    import mips_ctl_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] op_q,
    input  logic       mem_ready,
    output ctl_out_t   ctl
);

    always_comb begin
        // NOTE: full default before the case so no path can infer a latch.
        ctl = '0;
        unique case (state)
            S_FETCH: begin
                ctl.mem_read      = 1'b1;
                ctl.alu_src_a     = SRCA_PC;
                ctl.alu_src_b     = SRCB_FOUR;
                ctl.alu_operation = ALUOP_ADD;
                ctl.pc_src        = PCSRC_ALU;
                ctl.ir_write      = mem_ready;
                ctl.pc_write      = mem_ready;
            end
            S_DECODE: begin
                // Speculative branch target into ALUOut.
                ctl.alu_src_a     = SRCA_PC;
                ctl.alu_src_b     = SRCB_IMM_SH2;
                ctl.alu_operation = ALUOP_ADD;
            end
            S_MEM_ADDR: begin
                ctl.alu_src_a     = SRCA_REG;
                ctl.alu_src_b     = SRCB_IMM;
                ctl.alu_operation = ALUOP_ADD;
            end
            S_MEM_READ: begin
                ctl.mem_read = 1'b1;
                ctl.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                ctl.reg_write  = 1'b1;
                ctl.reg_dst    = REGDST_RT;
                ctl.mem_to_reg = M2R_MDR;
                ctl.instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                ctl.mem_write  = 1'b1;
                ctl.i_or_d     = 1'b1;
                ctl.instr_done = mem_ready;
            end
            S_R_EXEC: begin
                ctl.alu_src_a     = SRCA_REG;
                ctl.alu_src_b     = SRCB_REG;
                ctl.alu_operation = ALUOP_RTYPE;
            end
            S_R_WB: begin
                ctl.reg_write  = 1'b1;
                ctl.reg_dst    = REGDST_RD;
                ctl.mem_to_reg = M2R_ALUOUT;
                ctl.instr_done = 1'b1;
            end
            S_IMM_EXEC: begin
                ctl.alu_src_a     = SRCA_REG;
                ctl.alu_src_b     = SRCB_IMM;
                ctl.alu_operation = (op_q == OP_SLTI) ? ALUOP_SLTI : ALUOP_ADD;
            end
            S_IMM_WB: begin
                ctl.reg_write  = 1'b1;
                ctl.reg_dst    = REGDST_RT;
                ctl.mem_to_reg = M2R_ALUOUT;
                ctl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctl.alu_src_a     = SRCA_REG;
                ctl.alu_src_b     = SRCB_REG;
                ctl.alu_operation = ALUOP_SUB;
                ctl.pc_src        = PCSRC_ALUOUT;
                ctl.pc_write_eq   = (op_q == OP_BEQ);
                ctl.pc_write_ne   = (op_q == OP_BNE);
                ctl.instr_done    = 1'b1;
            end
            S_JUMP: begin
                ctl.pc_write   = 1'b1;
                ctl.pc_src     = PCSRC_JUMP;
                ctl.instr_done = 1'b1;
            end
            S_JAL: begin
                ctl.pc_write   = 1'b1;
                ctl.pc_src     = PCSRC_JUMP;
                ctl.reg_write  = 1'b1;
                ctl.reg_dst    = REGDST_R31;
                ctl.mem_to_reg = M2R_PC;
                ctl.instr_done = 1'b1;
            end
            S_JR: begin
                ctl.pc_write   = 1'b1;
                ctl.pc_src     = PCSRC_REG;
                ctl.instr_done = 1'b1;
            end
            S_ILLEGAL: begin
                ctl.illegal = 1'b1;
            end
            default: ctl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctl.sv
// Main control FSM for the multicycle MIPS datapath.
// Ports:
//   clk, rst        - clock; asynchronous active-low reset
//   opcode          - IR[31:26]; decoded in DECODE and latched there
//   function_       - IR[5:0]; distinguishes JR from other R-type ops
//   mem_ready       - memory completes this cycle; stalls FETCH/MEM_READ/MEM_WRITE
//   alu_operation.. - datapath mux selects, enables and strobes
//   instr_done      - final cycle of each retired instruction
//   illegal         - one-cycle pulse for an unsupported opcode
//   instr_count     - retired-instruction counter (illegal not counted)
module multicycle_ctl
    import mips_ctl_pkg::*;
#(
    parameter int         CNT_W    = 32,
    parameter logic [5:0] JR_FUNCT = 6'b001000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       function_,
    input  logic             mem_ready,
    output logic [1:0]       alu_operation,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_write_eq,
    output logic             pc_write_ne,
    output logic [1:0]       pc_src,
    output logic             reg_write,
    output logic [1:0]       reg_dst,
    output logic [1:0]       mem_to_reg,
    output logic             instr_done,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    state_t     state;
    logic [5:0] op_q;
    ctl_out_t   ctl;

    ctl_state_decode u_decode (
        .state     (state),
        .op_q      (op_q),
        .mem_ready (mem_ready),
        .ctl       (ctl)
    );

    // FSM register, opcode latch and retired counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_FETCH;
            op_q        <= '0;
            instr_count <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            if (ctl.instr_done)
                instr_count <= instr_count + CNT_W'(1);

            unique case (state)
                S_FETCH:
                    if (mem_ready) state <= S_DECODE;
                S_DECODE: begin
                    op_q <= opcode;
                    unique case (opcode)
                        OP_LW, OP_SW:   state <= S_MEM_ADDR;
                        OP_RTYPE:       state <= (function_ == JR_FUNCT) ? S_JR : S_R_EXEC;
                        OP_BEQ, OP_BNE: state <= S_BRANCH;
                        OP_ADDI,
                        OP_SLTI:        state <= S_IMM_EXEC;
                        OP_J:           state <= S_JUMP;
                        OP_JAL:         state <= S_JAL;
                        default:        state <= S_ILLEGAL;
                    endcase
                end
                S_MEM_ADDR:
                    state <= (op_q == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
                S_MEM_READ:
                    if (mem_ready) state <= S_MEM_WB;
                S_MEM_WRITE:
                    if (mem_ready) state <= S_FETCH;
                S_R_EXEC:   state <= S_R_WB;
                S_IMM_EXEC: state <= S_IMM_WB;
                default:    state <= S_FETCH; // single-cycle terminal states
            endcase
        end
    end

    // Fetch-side strobes and instr_done are forced low while reset is held,
    // since FETCH would otherwise drive them off mem_ready during reset.
    assign alu_operation = ctl.alu_operation;
    assign alu_src_a     = ctl.alu_src_a;
    assign alu_src_b     = ctl.alu_src_b;
    assign i_or_d        = ctl.i_or_d;
    assign mem_read      = ctl.mem_read   & rst;
    assign mem_write     = ctl.mem_write;
    assign ir_write      = ctl.ir_write   & rst;
    assign pc_write      = ctl.pc_write   & rst;
    assign pc_write_eq   = ctl.pc_write_eq;
    assign pc_write_ne   = ctl.pc_write_ne;
    assign pc_src        = ctl.pc_src;
    assign reg_write     = ctl.reg_write;
    assign reg_dst       = ctl.reg_dst;
    assign mem_to_reg    = ctl.mem_to_reg;
    assign instr_done    = ctl.instr_done & rst;
    assign illegal       = ctl.illegal;

endmodule
